// File: rtl/synth_pkg.sv
// Shared types, field positions and rate helper for the envelope path.
package synth_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;

  // Bit positions of the 2-bit codes inside amp_envelope
  localparam int ATK_LSB = 0;
  localparam int DEC_LSB = 2;
  localparam int SUS_LSB = 4;
  localparam int REL_LSB = 6;

  // Ticks per 1-LSB step: 1, 4, 16, 64
  function automatic logic [6:0] period_of(input logic [1:0] code);
    return 7'd1 << (2 * code);
  endfunction

endpackage

// File: rtl/env_prescaler.sv
// Sample-tick divider producing one step strobe per rate period.
module env_prescaler
  import synth_pkg::*;
#(
  parameter int DIV_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       sample_tick,
  input  logic [1:0] code,
  output logic       step
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] lim;

  // >= rather than == so a shortened period steps on the very next tick
  assign lim  = DIV_W'(period_of(code) - 7'd1);
  assign step = sample_tick & (cnt >= lim);

  // Count ticks; wrap on step, restart whenever the envelope changes phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clear)       cnt <= '0;
    else if (sample_tick) cnt <= step ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/adsr_envelope_gen.sv
// ADSR envelope: gate edge detect, five-state FSM and saturating level.
module adsr_envelope_gen
  import synth_pkg::*;
#(
  parameter int LEVEL_W = 8,
  parameter int DIV_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_tick,
  input  logic               note_on,
  input  logic [7:0]         amp_envelope,
  output logic [LEVEL_W-1:0] env_level,
  output logic [2:0]         env_state,
  output logic               env_busy
);

  env_state_t        state, state_nxt;
  logic [LEVEL_W-1:0] level, level_nxt;
  logic               gate_q, rise, fall;
  logic               trans, step;
  logic [1:0]         rate_code, sus;
  logic [LEVEL_W-1:0] target;

  assign rise   = note_on & ~gate_q;
  assign fall   = ~note_on & gate_q;
  assign sus    = amp_envelope[SUS_LSB +: 2];
  assign target = {sus, sus, sus, sus};

  // Rate code for the current phase; sustain tracking uses the decay rate
  always_comb begin
    case (state)
      ATTACK:  rate_code = amp_envelope[ATK_LSB +: 2];
      RELEASE: rate_code = amp_envelope[REL_LSB +: 2];
      default: rate_code = amp_envelope[DEC_LSB +: 2];
    endcase
  end

  env_prescaler #(.DIV_W(DIV_W)) u_presc (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (trans),
    .sample_tick (sample_tick),
    .code        (rate_code),
    .step        (step)
  );

  // Next state / level: rise > fall > level bound > step; no step on a transition
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    trans     = 1'b0;
    if (rise) begin
      state_nxt = ATTACK;
      trans     = 1'b1;
    end else if (fall && (state == ATTACK || state == DECAY || state == SUSTAIN)) begin
      state_nxt = RELEASE;
      trans     = 1'b1;
    end else begin
      case (state)
        ATTACK: begin
          if (level == '1) begin
            state_nxt = DECAY;
            trans     = 1'b1;
          end else if (step) level_nxt = level + 1'b1;
        end
        DECAY: begin
          if (level <= target) begin
            state_nxt = SUSTAIN;
            trans     = 1'b1;
          end else if (step) level_nxt = level - 1'b1;
        end
        SUSTAIN: begin
          if (step && level < target)      level_nxt = level + 1'b1;
          else if (step && level > target) level_nxt = level - 1'b1;
        end
        RELEASE: begin
          if (level == '0) begin
            state_nxt = IDLE;
            trans     = 1'b1;
          end else if (step) level_nxt = level - 1'b1;
        end
        default: level_nxt = '0;
      endcase
    end
  end

  // State, level and gate history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      level  <= '0;
      gate_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      gate_q <= note_on;
    end
  end

  assign env_level = level;
  assign env_state = state;
  assign env_busy  = (state != IDLE);

endmodule

// File: doc/adsr_envelope_gen.md
Name: adsr_envelope_gen

Overview:
- Downstream consumer of the keypad decoder's amp_envelope byte.
- Turns the four 2-bit ADSR codes plus a note gate into an 8-bit amplitude level, updated at sample rate.
- The level feeds the output multiplier after the waveform and filter path.
- Contains a five-state ADSR FSM, a per-step prescaler and gate edge detection.

Parameters:
- LEVEL_W, 8, envelope level width; the logic is specified for 8 only.
- DIV_W, 6, prescaler counter width; must hold the longest period, 64.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_tick  in  1  one-cycle strobe at sample rate; all stepping is gated by it
- note_on  in  1  note gate, synchronous to clk, high while a note is held
- amp_envelope  in  8  [1:0] attack code, [3:2] decay code, [5:4] sustain code, [7:6] release code
- env_level  out  LEVEL_W  current envelope amplitude, 0 = silent, 255 = full
- env_state  out  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
- env_busy  out  1  high when env_state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - env_level = 0, env_state = IDLE, env_busy = 0.
  - Prescaler = 0; registered previous gate = 0.
- Gate edges: rise = note_on & ~gate_q; fall = ~note_on & gate_q. gate_q updates every clk, independent of sample_tick.
- Step period in ticks per 1-LSB level step: code 0 -> 1, code 1 -> 4, code 2 -> 16, code 3 -> 64 (1 << 2*code).
  - Attack, decay and release codes are read live from amp_envelope.
- Sustain target = {s,s,s,s}, where s is the 2-bit sustain code: 0x00, 0x55, 0xAA, 0xFF. Read live.
- Prescaler:
  - On sample_tick, if prescaler == period-1: take one step and clear the prescaler; otherwise increment it.
  - Cleared on every state change.
  - A period change mid-count takes effect at the next compare; if prescaler >= new period-1, the step happens on the next tick.
- Transition priority per clk: rise > fall > level-based transition > step.
  - rise, from any state: -> ATTACK. Level is kept, not reset to 0 (legato retrigger).
  - fall, in ATTACK, DECAY or SUSTAIN: -> RELEASE. fall in IDLE or RELEASE: ignored.
  - ATTACK: step +1. When env_level == 255 -> DECAY.
  - DECAY: step -1. When env_level <= target -> SUSTAIN.
  - SUSTAIN: if env_level != target, step ±1 toward target at the decay rate; stay in SUSTAIN. A held note follows live sustain edits.
  - RELEASE: step -1. When env_level == 0 -> IDLE.
  - IDLE: level held at 0.
- Level-based transitions are evaluated every clk on the registered level, not only on ticks.
  - The transition occurs on the clk after the level reaches its bound.
  - No step is taken in the transition cycle.
- Saturation: level never wraps.
  - +1 at 255 is suppressed; -1 at 0 is suppressed.
- Latency: env_level changes on the clk edge that samples the qualifying sample_tick; env_state changes one clk after the causing condition.
- rst_n asserted mid-envelope returns to reset values immediately. After deassert, a note_on already high counts as a rise on the first clk.
- sample_tick held high is legal: the block steps every clk.

Decomposition:
- Package synth_pkg:
  - env_state_t enum with the five states above.
  - Field index constants ATK_LSB=0, DEC_LSB=2, SUS_LSB=4, REL_LSB=6.
  - Function period_of(code) returning 1 << 2*code.
- Sub-module env_prescaler:
  - Inputs: clk, rst_n, clear, sample_tick, code.
  - Output: step strobe.
  - Instanced once; its code input is muxed by state.

Test Plan:
- amp_envelope=0x00, note_on rise, tick every clk:
  - ATTACK reaches 255 after 255 ticks.
  - DECAY falls to 0, then SUSTAIN; env_busy=1 throughout.
- amp_envelope=0x24 (A=0, D=1, S=2):
  - Attack 255 ticks; decay 255->0xAA takes 85*4=340 ticks; SUSTAIN holds 0xAA while the gate is high.
- Release and retrigger:
  - In SUSTAIN at 0xAA, release code 3: drop note_on. Expect RELEASE with one step per 64 ticks.
  - Re-raise note_on at level 0xA0: expect ATTACK starting from 0xA0 with no jump to 0, then climbing to 255.
- In SUSTAIN at 0x55, change the sustain code to 3:
  - Level ramps up at the decay rate to 0xFF; state stays SUSTAIN.
- Assert rst_n low mid-ATTACK at level 0x40:
  - Outputs go to 0 / IDLE asynchronously, before the next clk.
  - Release reset with note_on high: ATTACK begins on the first clk.
- Prescaler behaviour, attack code 2:
  - Hold sample_tick low for 100 clks: no level change.
  - Then 16 ticks give exactly one +1 step.
